// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the MEM-stage pipeline owns the single-port RAM by default,
// and the debug unit takes idle cycles or steals one cycle after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_re,
  input  logic              pipe_we,
  input  logic [31:0]       pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  output logic              pipe_addr_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {IDLE = 1'b0, STEAL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               rd_pipe_q, rd_pipe_d;
  logic               rd_dbg_q, rd_dbg_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  pipe_hold_q, dbg_hold_q;

  logic               pipe_act;
  logic               pipe_oob;
  logic [ADDR_W-1:0]  pipe_word;
  logic               unused_addr_lsb;

  assign pipe_act        = pipe_re | pipe_we;
  assign pipe_oob        = |pipe_addr[31:ADDR_W+2];
  assign pipe_word       = pipe_addr[ADDR_W+1:2];
  assign unused_addr_lsb = ^pipe_addr[1:0];

  // Debug handshake: an access is transferred in exactly the cycle where dbg_req and
  // dbg_gnt are both high; dbg_gnt never rises without dbg_req. A granted read returns
  // its data with a one-cycle dbg_rvalid pulse on the following cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    rd_pipe_d     = 1'b0;
    rd_dbg_d      = 1'b0;
    err_d         = 1'b0;
    pipe_stall    = 1'b0;
    pipe_addr_err = 1'b0;
    dbg_gnt       = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (pipe_act) begin
            if (pipe_oob) begin
              pipe_addr_err = 1'b1;
              err_d         = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_we    = pipe_we;
              mem_addr  = pipe_word;
              mem_wdata = pipe_we ? pipe_wdata : '0;
              rd_pipe_d = ~pipe_we;
            end
            // Denied debug request: count it, and steal the next cycle once patience runs out.
            if (dbg_req) begin
              if (wait_cnt_q == WAIT_LAST) state_d = STEAL;
              else                         wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end else if (dbg_req) begin
            dbg_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_we ? dbg_wdata : '0;
            rd_dbg_d  = ~dbg_we;
          end
        end
        STEAL: begin
          pipe_stall = 1'b1;
          state_d    = IDLE;
          if (dbg_req) begin
            dbg_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_we ? dbg_wdata : '0;
            rd_dbg_d  = ~dbg_we;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read return path: RAM data is steered combinationally in the cycle it arrives and
  // captured so each side keeps showing its last result.
  always_comb begin
    pipe_rdata = pipe_hold_q;
    dbg_rdata  = dbg_hold_q;
    dbg_rvalid = rd_dbg_q;
    if (err_q)          pipe_rdata = '0;
    else if (rd_pipe_q) pipe_rdata = mem_rdata;
    if (rd_dbg_q)       dbg_rdata  = mem_rdata;
    if (reset) begin
      pipe_rdata = '0;
      dbg_rdata  = '0;
      dbg_rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      rd_pipe_q   <= 1'b0;
      rd_dbg_q    <= 1'b0;
      err_q       <= 1'b0;
      pipe_hold_q <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_dbg_q    <= rd_dbg_d;
      err_q       <= err_d;
      pipe_hold_q <= pipe_rdata;
      dbg_hold_q  <= dbg_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, word-address width (256 words); DATA_W, default 32, data width; MAX_WAIT, default 4, number of denied debug cycles before a steal.
REQ-002 Ports SHALL be exactly:
  clk  in  1  clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  pipe_re  in  1  MEM-stage load request
  pipe_we  in  1  MEM-stage store request
  pipe_addr  in  32  MEM-stage byte address
  pipe_wdata  in  DATA_W  store data
  pipe_rdata  out  DATA_W  load data, valid one cycle after the granted load
  pipe_stall  out  1  pipeline must hold its request this cycle
  pipe_addr_err  out  1  one-cycle pulse, out-of-range pipeline access
  dbg_req  in  1  debug-unit access request
  dbg_we  in  1  debug write (1) or read (0)
  dbg_addr  in  ADDR_W  debug word address
  dbg_wdata  in  DATA_W  debug write data
  dbg_gnt  out  1  debug access accepted this cycle
  dbg_rvalid  out  1  debug read data valid
  dbg_rdata  out  DATA_W  debug read data
  mem_en  out  1  memory access enable
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_W  memory word address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  synchronous-read data, one cycle after mem_en with mem_we=0
REQ-003 Reset SHALL be: reset, synchronous, active-high; clock SHALL be clk.

Function
REQ-004 FSM states SHALL be IDLE and STEAL; wait_cnt SHALL be a counter of width clog2(MAX_WAIT)+1.
REQ-005 pipe_act = pipe_re | pipe_we; pipe_we SHALL take priority when both are high (treated as a store).
REQ-006 Pipeline word address SHALL be pipe_addr[ADDR_W+1:2]; pipe_addr[1:0] SHALL be ignored.
REQ-007 If pipe_act and pipe_addr[31:ADDR_W+2] != 0, the access SHALL be suppressed (no mem_en), pipe_addr_err SHALL pulse that cycle, and pipe_rdata SHALL be zero the following cycle.
REQ-008 In IDLE with pipe_act: the memory port SHALL be driven from pipe_*; dbg_gnt SHALL be 0; pipe_stall SHALL be 0.
REQ-009 In IDLE with !pipe_act and dbg_req: dbg_gnt SHALL be 1 (combinational, same cycle) and the memory port SHALL be driven from dbg_*.
REQ-010 In IDLE, each cycle with dbg_req=1 and dbg_gnt=0 SHALL increment wait_cnt; any grant or dbg_req=0 SHALL clear it.
REQ-011 When wait_cnt reaches MAX_WAIT-1 while still denied, the next state SHALL be STEAL.
REQ-012 In STEAL: pipe_stall SHALL be 1, dbg_gnt SHALL equal dbg_req, the memory port SHALL be driven from dbg_*, and the next state SHALL be IDLE unconditionally.
REQ-013 In STEAL with dbg_req=0 (request withdrawn), the cycle SHALL be idle (mem_en=0) with pipe_stall still 1.
REQ-014 An owner register SHALL record who issued each read; exactly one cycle after a granted read, mem_rdata SHALL appear on pipe_rdata or dbg_rdata according to the owner, and dbg_rvalid SHALL pulse for debug reads only.
REQ-015 pipe_rdata and dbg_rdata SHALL hold their last value when no read completes.
REQ-016 When mem_en=0, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-017 A debug write SHALL produce no dbg_rvalid.

Reset
REQ-018 While reset is high: the state SHALL be IDLE, wait_cnt 0, and the owner register cleared; all outputs SHALL be 0 on the cycle after reset, including pipe_rdata, dbg_rdata, pipe_stall and dbg_gnt.
REQ-019 A read in flight when reset is asserted SHALL be discarded (no rvalid after reset).

Verification
REQ-020 Pipeline store pipe_we=1, addr=0x10, data=0xDEADBEEF; next cycle pipe_re=1, addr=0x10 -> mem_addr=4, and pipe_rdata=0xDEADBEEF one cycle after the load.
REQ-021 Pipeline idle; debug read dbg_addr=4 -> dbg_gnt=1 the same cycle; dbg_rvalid=1 with dbg_rdata=0xDEADBEEF the next cycle; pipe_stall stays 0.
REQ-022 Pipeline busy every cycle; dbg_req held with MAX_WAIT=4 -> denied for 4 cycles, 5th cycle is STEAL: pipe_stall=1, dbg_gnt=1; 6th cycle pipe_stall=0 and the pipeline access proceeds.
REQ-023 pipe_re=1, pipe_addr=0x400 -> mem_en=0, pipe_addr_err pulses 1 cycle, pipe_rdata=0 the next cycle.
REQ-024 Debug read granted, reset asserted the following cycle -> dbg_rvalid stays 0, all outputs 0, state IDLE.
REQ-025 pipe_re=1 and pipe_we=1 together at addr 0x8, data 0x5 -> mem_we=1, memory word 2 = 0x5, no read response.
